// File: rtl/adder_pkg.sv
// Shared encodings for the chunked adder: FSM states and operation codes.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_chain.sv
// Combinational ripple of CHUNK full-adder cells; zero latency, no flow control.
// c_msb_o is the carry into the top cell, used upstream for signed overflow.
module fa_chain #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o    = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Add/subtract one CHUNK slice per cycle, LSB first; result valid NCH cycles after accept.
// Single operation in flight: in_ready_o low from accept until the result is taken (out_ready_i).
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, in_ready_q, out_valid_q, cout_q, ovf_q, zero_q;

  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             co_sl, cmsb_sl, last_sl;
  logic [WIDTH-1:0] sum_d;

  assign a_sl    = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl    = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last_sl = (idx_q == IW'(NCH - 1));

  fa_chain #(.CHUNK(CHUNK)) u_chain (
    .a_i     (a_sl),
    .b_i     (b_sl),
    .ci_i    (carry_q),
    .s_o     (s_sl),
    .co_o    (co_sl),
    .c_msb_o (cmsb_sl)
  );

  // Merged view of the sum including this cycle's slice, so zero sees the whole word.
  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_sl;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            b_q        <= (op_i == OP_SUB) ? ~b_i : b_i;
            carry_q    <= (op_i == OP_SUB) ? 1'b1 : cin_i;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= co_sl;
          idx_q   <= idx_q + 1'b1;
          if (last_sl) begin
            cout_q      <= co_sl;
            ovf_q       <= co_sl ^ cmsb_sl;
            zero_q      <= ~|sum_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three configurations (8/4, 32/8, 16/16) against an arithmetic model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] in_valid, op_v, cin_v, out_ready;
  logic [2:0] in_ready, out_valid, cout, ovf, zero;
  logic [7:0]  a0, b0, s0;
  logic [31:0] a1, b1, s1;
  logic [15:0] a2, b2, s2;
  logic [31:0] sum [3];

  assign sum[0] = {24'd0, s0};
  assign sum[1] = s1;
  assign sum[2] = {16'd0, s2};

  int n_cmp = 0;
  int n_bad = 0;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .op_i(op_v[0]), .a_i(a0), .b_i(b0), .cin_i(cin_v[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .sum_o(s0),
    .cout_o(cout[0]), .ovf_o(ovf[0]), .zero_o(zero[0]));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .op_i(op_v[1]), .a_i(a1), .b_i(b1), .cin_i(cin_v[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .sum_o(s1),
    .cout_o(cout[1]), .ovf_o(ovf[1]), .zero_o(zero[1]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .op_i(op_v[2]), .a_i(a2), .b_i(b2), .cin_i(cin_v[2]),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .sum_o(s2),
    .cout_o(cout[2]), .ovf_o(ovf[2]), .zero_o(zero[2]));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 32 : 16;
  endfunction

  function automatic int nch_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction

  task automatic set_ops(input int d, input logic [31:0] a, input logic [31:0] b);
    case (d)
      0:       begin a0 = a[7:0];  b0 = b[7:0];  end
      1:       begin a1 = a;       b1 = b;       end
      default: begin a2 = a[15:0]; b2 = b[15:0]; end
    endcase
  endtask

  // Reference: unbounded integer arithmetic, then wrap; overflow from signed range.
  task automatic model(input int w, input bit op, input longint unsigned a, input longint unsigned b,
                       input bit cin, output longint unsigned s, output bit co, output bit ov, output bit z);
    longint unsigned m, full;
    longint sa, sb, sr, maxp, minn;
    m    = (64'd1 << w) - 1;
    sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    maxp = longint'(64'd1 << (w - 1)) - 1;
    minn = -longint'(64'd1 << (w - 1));
    if (!op) begin
      full = a + b + 64'(cin);
      sr   = sa + sb + longint'(cin);
    end else begin
      full = a + ((~b) & m) + 1;
      sr   = sa - sb;
    end
    s  = full & m;
    co = full[w];
    ov = (sr > maxp) || (sr < minn);
    z  = (s == 0);
  endtask

  task automatic run_op(input int d, input bit op, input logic [31:0] a_raw, input logic [31:0] b_raw,
                        input bit cin, input int stall, input bit pulse, input string tag);
    longint unsigned m, a, b, es;
    bit eco, eov, ez;
    int n;
    m = (64'd1 << width_of(d)) - 1;
    a = 64'(a_raw) & m;
    b = 64'(b_raw) & m;
    model(width_of(d), op, a, b, cin, es, eco, eov, ez);
    check_eq({tag, " idle_rdy"}, 64'(in_ready[d]), 64'd1);
    set_ops(d, a[31:0], b[31:0]);
    op_v[d] = op;
    cin_v[d] = cin;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    set_ops(d, $urandom, $urandom);
    op_v[d] = 1'($urandom);
    cin_v[d] = 1'($urandom);
    if (stall == 0) out_ready[d] = 1'b1;
    check_eq({tag, " run_rdy"}, 64'(in_ready[d]), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid[d] && n < 100);
    check_eq({tag, " latency"}, 64'(n), 64'(nch_of(d)));
    check_eq({tag, " sum"}, 64'(sum[d]), es);
    check_eq({tag, " cout"}, 64'(cout[d]), 64'(eco));
    check_eq({tag, " ovf"}, 64'(ovf[d]), 64'(eov));
    check_eq({tag, " zero"}, 64'(zero[d]), 64'(ez));
    check_eq({tag, " done_rdy"}, 64'(in_ready[d]), 64'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid[d] = (pulse && i == 1);
      @(posedge clk); #1;
      check_eq({tag, " hold_vld"}, 64'(out_valid[d]), 64'd1);
      check_eq({tag, " hold_sum"}, 64'(sum[d]), es);
      check_eq({tag, " hold_rdy"}, 64'(in_ready[d]), 64'd0);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check_eq({tag, " taken_vld"}, 64'(out_valid[d]), 64'd0);
    check_eq({tag, " taken_rdy"}, 64'(in_ready[d]), 64'd1);
    check_eq({tag, " kept_sum"}, 64'(sum[d]), es);
    if (pulse) begin
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, " no_extra"}, 64'(out_valid[d]), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = '0; op_v = '0; cin_v = '0; out_ready = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst in_ready", 64'(in_ready[d]), 64'd1);
      check_eq("rst out_valid", 64'(out_valid[d]), 64'd0);
      check_eq("rst sum", 64'(sum[d]), 64'd0);
      check_eq("rst flags", 64'({cout[d], ovf[d], zero[d]}), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 1'b0, 32'h7F, 32'h01, 1'b0, 2, 1'b0, "t1 7F+01");
    check_eq("t1 const", 64'({sum[0][7:0], cout[0], ovf[0], zero[0]}), 64'({8'h80, 3'b010}));
    run_op(0, 1'b1, 32'h05, 32'h07, 1'b1, 1, 1'b0, "t2 05-07");
    check_eq("t2a const", 64'({sum[0][7:0], cout[0], ovf[0]}), 64'({8'hFE, 2'b00}));
    run_op(0, 1'b1, 32'h07, 32'h05, 1'b0, 0, 1'b0, "t2 07-05");
    check_eq("t2b const", 64'({sum[0][7:0], cout[0]}), 64'({8'h02, 1'b1}));
    run_op(0, 1'b0, 32'hFF, 32'h00, 1'b1, 0, 1'b0, "t3 FF+00+1");
    check_eq("t3 const", 64'({sum[0][7:0], cout[0], ovf[0], zero[0]}), 64'({8'h00, 3'b101}));
    run_op(0, 1'b0, 32'h3C, 32'h41, 1'b0, 5, 1'b1, "t4 stall");

    // Abort after the first slice has been written.
    set_ops(0, 32'h12, 32'h34);
    op_v[0] = 1'b0; cin_v[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("t5 rst out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("t5 rst in_ready", 64'(in_ready[0]), 64'd1);
    check_eq("t5 rst sum", 64'(sum[0]), 64'd0);
    check_eq("t5 rst flags", 64'({cout[0], ovf[0], zero[0]}), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(0, 1'b0, 32'h12, 32'h34, 1'b0, 1, 1'b0, "t5 12+34");
    check_eq("t5 const", 64'(sum[0]), 64'h46);

    for (int d = 1; d < 3; d++) begin
      for (int k = 0; k < 1000; k++) begin
        run_op(d, 1'($urandom), $urandom, $urandom, 1'($urandom),
               int'($urandom_range(0, 3)), 1'b0, (d == 1) ? "rnd32" : "rnd16");
      end
    end
    run_op(1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0, "e32 min-1");
    run_op(2, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b0, 0, 1'b0, "e16 x-x");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
